hazard_ctrl: RTL and testbench

Pipeline hazard controller for the five-stage LEGv8 CPU. It keeps its own shadow copy of the destination-register information for the instructions in EX and MEM. From that copy and the ID-stage instruction fields it drives four things:
- forward_Da / forward_Db for the datapath's ID-stage operand muxes;
- the load-use stall, which freezes PC and IF/ID;
- bubble insertion into ID/EX;
- a saturating stall-cycle performance counter.

It sits in cpu_controlpath, between instruction decode and the datapath.

---
 rtl/hazard_ctrl.sv | 101 ++++++++++
 tb/tb_hazard_ctrl.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Hazard controller for the five-stage LEGv8 pipeline: operand forwarding,
// load-use stall/bubble and a saturating stall-cycle counter.
module hazard_ctrl #(
  parameter int REG_W    = 5,
  parameter int ZERO_REG = 31,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_Rn,
  input  logic [REG_W-1:0] id_Rm,
  input  logic             id_use_a,
  input  logic             id_use_b,
  input  logic [REG_W-1:0] id_Rd,
  input  logic             id_RegWren,
  input  logic             id_Mem2Reg,
  output logic [1:0]       forward_Da,
  output logic [1:0]       forward_Db,
  output logic             stall,
  output logic             bubble,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [REG_W-1:0] XZR = REG_W'(ZERO_REG);

  logic             ex_valid_q, ex_valid_d;
  logic [REG_W-1:0] ex_rd_q, ex_rd_d;
  logic             ex_wren_q, ex_wren_d;
  logic             ex_load_q, ex_load_d;
  // MEM forwards loads and ALU results alike, so its load flag is not kept.
  logic             mem_valid_q;
  logic [REG_W-1:0] mem_rd_q;
  logic             mem_wren_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic ex_hit_a, ex_hit_b, mem_hit_a, mem_hit_b, load_use;

  assign ex_hit_a  = ex_valid_q  & ex_wren_q  & (ex_rd_q  == id_Rn) & (id_Rn != XZR);
  assign ex_hit_b  = ex_valid_q  & ex_wren_q  & (ex_rd_q  == id_Rm) & (id_Rm != XZR);
  assign mem_hit_a = mem_valid_q & mem_wren_q & (mem_rd_q == id_Rn) & (id_Rn != XZR);
  assign mem_hit_b = mem_valid_q & mem_wren_q & (mem_rd_q == id_Rm) & (id_Rm != XZR);

  assign load_use = id_valid & ex_load_q &
                    ((id_use_a & ex_hit_a) | (id_use_b & ex_hit_b));

  always_comb begin
    forward_Da = 2'b00;
    forward_Db = 2'b00;
    // The younger EX producer wins over MEM; a load in EX cannot forward yet.
    if (id_use_a && ex_hit_a && !ex_load_q) forward_Da = 2'b01;
    else if (id_use_a && mem_hit_a)         forward_Da = 2'b10;
    if (id_use_b && ex_hit_b && !ex_load_q) forward_Db = 2'b01;
    else if (id_use_b && mem_hit_b)         forward_Db = 2'b10;
  end

  always_comb begin
    ex_valid_d = id_valid;
    ex_rd_d    = id_Rd;
    ex_wren_d  = id_RegWren;
    ex_load_d  = id_Mem2Reg;
    if (load_use) begin
      ex_valid_d = 1'b0;
      ex_rd_d    = '0;
      ex_wren_d  = 1'b0;
      ex_load_d  = 1'b0;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (load_use && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid_q  <= 1'b0;
      ex_rd_q     <= '0;
      ex_wren_q   <= 1'b0;
      ex_load_q   <= 1'b0;
      mem_valid_q <= 1'b0;
      mem_rd_q    <= '0;
      mem_wren_q  <= 1'b0;
      cnt_q       <= '0;
    end else begin
      mem_valid_q <= ex_valid_q;
      mem_rd_q    <= ex_rd_q;
      mem_wren_q  <= ex_wren_q;
      ex_valid_q  <= ex_valid_d;
      ex_rd_q     <= ex_rd_d;
      ex_wren_q   <= ex_wren_d;
      ex_load_q   <= ex_load_d;
      cnt_q       <= cnt_d;
    end
  end

  assign stall     = load_use;
  assign bubble    = load_use;
  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: a driver predicts each cycle's response from
// an instruction-history model, a negedge monitor pops and compares.
module tb_hazard_ctrl;

  localparam int CNT_W = 2;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic reset;
  logic id_valid, id_use_a, id_use_b, id_RegWren, id_Mem2Reg;
  logic [4:0] id_Rn, id_Rm, id_Rd;
  logic [1:0] forward_Da, forward_Db;
  logic stall, bubble;
  logic [CNT_W-1:0] stall_cnt;

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_W(5), .ZERO_REG(31), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_Rn(id_Rn), .id_Rm(id_Rm),
    .id_use_a(id_use_a), .id_use_b(id_use_b), .id_Rd(id_Rd),
    .id_RegWren(id_RegWren), .id_Mem2Reg(id_Mem2Reg),
    .forward_Da(forward_Da), .forward_Db(forward_Db), .stall(stall),
    .bubble(bubble), .stall_cnt(stall_cnt)
  );

  typedef struct { bit v; int rd; bit w; bit ld; } instr_t;
  typedef struct { logic [1:0] fa; logic [1:0] fb; logic st; int cnt; } exp_t;

  instr_t hist[$];   // instructions that left ID, youngest last
  exp_t   sb[$];
  int     model_cnt = 0;
  bit     known = 0;
  int     n_cmp = 0, n_bad = 0;
  bit     done = 0;

  function automatic bit writes(instr_t e, int r);
    return e.v && e.w && e.rd == r && r != 31;
  endfunction

  function automatic instr_t age(int n);  // 1 = in EX, 2 = in MEM
    return hist[hist.size()-n];
  endfunction

  function automatic bit exp_stall();
    instr_t ex = age(1);
    return id_valid && ex.ld &&
      ((id_use_a && writes(ex, int'(id_Rn))) || (id_use_b && writes(ex, int'(id_Rm))));
  endfunction

  function automatic logic [1:0] exp_fwd(bit use_r, int r);
    if (use_r && writes(age(1), r) && !age(1).ld) return 2'b01;
    if (use_r && writes(age(2), r)) return 2'b10;
    return 2'b00;
  endfunction

  task automatic step(input bit rst, input bit v, input int rn, input int rm,
                      input bit ua, input bit ub, input int rd, input bit w, input bit ld);
    instr_t nop = '{0, 0, 0, 0};
    instr_t cur;
    exp_t e;
    @(posedge clk);
    if (reset) begin
      hist = {nop, nop};
      model_cnt = 0;
      known = 1;
    end else if (known) begin
      bit s = exp_stall();
      cur = '{id_valid, int'(id_Rd), id_RegWren, id_Mem2Reg};
      hist.push_back(s ? nop : cur);
      void'(hist.pop_front());
      if (s && model_cnt < CMAX) model_cnt++;
    end
    #1;
    reset = rst; id_valid = v; id_Rn = 5'(rn); id_Rm = 5'(rm);
    id_use_a = ua; id_use_b = ub; id_Rd = 5'(rd); id_RegWren = w; id_Mem2Reg = ld;
    if (known && !rst) begin
      e.st  = exp_stall();
      e.fa  = exp_fwd(ua, rn);
      e.fb  = exp_fwd(ub, rm);
      e.cnt = model_cnt;
      sb.push_back(e);
    end
  endtask

  task automatic alu(int rd, int rn, int rm); step(0, 1, rn, rm, 1, 1, rd, 1, 0); endtask
  task automatic ldur(int rd, int rn);        step(0, 1, rn, 0, 1, 0, rd, 1, 1); endtask
  task automatic stur(int rt, int rn);        step(0, 1, rn, rt, 1, 1, rt, 0, 1); endtask

  function automatic int rreg();
    return ($urandom_range(0, 9) == 0) ? 31 : int'($urandom_range(0, 3));
  endfunction

  task automatic check(string name, int act, int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    while (!done) begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("stall", int'(stall), int'(e.st));
        check("bubble", int'(bubble), int'(e.st));
        check("stall_cnt", int'(stall_cnt), e.cnt);
        if (!e.st) begin
          check("forward_Da", int'(forward_Da), int'(e.fa));
          check("forward_Db", int'(forward_Db), int'(e.fb));
        end
      end
    end
  end

  initial begin : driver
    reset = 1; id_valid = 0; id_Rn = 0; id_Rm = 0; id_use_a = 0; id_use_b = 0;
    id_Rd = 0; id_RegWren = 0; id_Mem2Reg = 0;
    repeat (2) step(1, 1'($urandom), rreg(), rreg(), 1'($urandom), 1'($urandom),
                    rreg(), 1'($urandom), 1'($urandom));
    // forwarding EX then MEM
    alu(1, 5, 6); alu(2, 1, 3); alu(4, 5, 1);
    // load-use, then the held consumer gets MEM forwarding
    ldur(1, 7); alu(2, 1, 1); alu(2, 1, 1);
    // EX beats MEM
    alu(1, 5, 6); alu(1, 5, 6); alu(2, 1, 1);
    // XZR, stores, invalid ID
    alu(31, 5, 6); alu(5, 31, 31);
    ldur(31, 7); alu(5, 31, 31);
    stur(8, 7); alu(5, 8, 8);
    ldur(1, 7); step(0, 0, 1, 1, 1, 1, 9, 1, 0);
    // counter saturation
    for (int i = 0; i < 5; i++) begin ldur(1, 7); alu(2, 1, 1); alu(2, 1, 1); end
    // reset on a stall cycle
    ldur(1, 7); step(1, 1, 1, 1, 1, 1, 2, 1, 0); alu(2, 1, 1);
    // randomized traffic
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 99) < 2, $urandom_range(0, 9) != 0, rreg(), rreg(),
           1'($urandom), 1'($urandom), rreg(), $urandom_range(0, 3) != 0,
           $urandom_range(0, 2) == 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    done = 1;
    @(negedge clk);
    if (sb.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL scoreboard_drain: %0d left, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
